// File: rtl/up_counter.sv
`default_nettype none
// ============================================================================
// Module      : up_counter
// Description : Enable-gated up counter with a programmable step and terminal
//               count. When a step would pass TERMINAL, the count wraps modulo
//               TERMINAL+1. Each wrap gives a one-cycle overflow pulse and sets
//               a sticky overflow flag. Typical uses are a watchdog timer (a
//               timeout is an overflow between clear kicks) and a generic
//               event or cycle counter.
//
// Parameters  : WIDTH          - counter width in bits (>= 1)
//               INCREMENT_RATE - step added on each enabled cycle (1..TERMINAL)
//               TERMINAL       - highest count value (<= 2**WIDTH-1)
//
// Ports       : clk             in   rising-edge clock
//               rst             in   asynchronous active-high reset
//               en              in   count enable
//               clear           in   synchronous clear of count and flags
//               load            in   synchronous load of load_val (clamped)
//               load_val        in   [WIDTH] value for load
//               count_val       out  [WIDTH] current count (registered)
//               overflow        out  one-cycle pulse on wrap (registered)
//               overflow_sticky out  set on any overflow, cleared by rst/clear
//
// Options     : UP_COUNTER_SATURATE_EN - when defined, the count saturates at
//               TERMINAL instead of wrapping. overflow pulses once when
//               saturation is first reached. clear or load ends saturation.
//
// Revision    : 1.0 - initial release
// ============================================================================
module up_counter #(
  parameter int WIDTH          = 5,
  parameter int INCREMENT_RATE = 1,
  parameter int TERMINAL       = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_val,
  output logic             overflow,
  output logic             overflow_sticky
);

  // All arithmetic uses WIDTH+1 bits, so count+step can never truncate.
  localparam logic [WIDTH:0] C_TERM = (WIDTH + 1)'(TERMINAL);
  localparam logic [WIDTH:0] C_INC  = (WIDTH + 1)'(INCREMENT_RATE);

  generate
    if ((INCREMENT_RATE < 1) || (INCREMENT_RATE > TERMINAL) ||
        (TERMINAL > (2 ** WIDTH) - 1) || (WIDTH < 1)) begin : g_param_error
      $error("up_counter: illegal parameters WIDTH=%0d INCREMENT_RATE=%0d TERMINAL=%0d",
             WIDTH, INCREMENT_RATE, TERMINAL);
    end
  endgenerate

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] load_clamped;
`ifdef UP_COUNTER_SATURATE_EN
  // Marks that the count is pinned at TERMINAL. It stops the pulse from
  // repeating while en stays high.
  logic             saturated;
`else
  logic [WIDTH-1:0] wrapped;
  // TERMINAL+1 can be as large as 2**WIDTH, so it needs the extra bit.
  localparam logic [WIDTH:0] C_MODULUS = C_TERM + (WIDTH + 1)'(1);
`endif

  always_comb begin
    sum          = {1'b0, count_val} + C_INC;
    load_clamped = ({1'b0, load_val} > C_TERM) ? C_TERM[WIDTH-1:0] : load_val;
`ifndef UP_COUNTER_SATURATE_EN
    // The step is at most TERMINAL, so one subtraction always lands in range.
    wrapped      = WIDTH'(sum - C_MODULUS);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_val       <= '0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
`ifdef UP_COUNTER_SATURATE_EN
      saturated       <= 1'b0;
`endif
    end else if (clear) begin
      count_val       <= '0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
`ifdef UP_COUNTER_SATURATE_EN
      saturated       <= 1'b0;
`endif
    end else if (load) begin
      count_val       <= load_clamped;
      overflow        <= 1'b0;
`ifdef UP_COUNTER_SATURATE_EN
      saturated       <= 1'b0;
`endif
    end else if (en) begin
      if (sum > C_TERM) begin
`ifdef UP_COUNTER_SATURATE_EN
        count_val     <= C_TERM[WIDTH-1:0];
        overflow      <= ~saturated;
        saturated     <= 1'b1;
`else
        count_val     <= wrapped;
        overflow      <= 1'b1;
`endif
        overflow_sticky <= 1'b1;
      end else begin
        count_val     <= sum[WIDTH-1:0];
        overflow      <= 1'b0;
      end
    end else begin
      overflow        <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_up_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_counter
// Description : Self-checking bench for up_counter. It builds three
//               instances with different parameters:
//                 u0 - WIDTH=5, TERMINAL=31, step 1
//                 u1 - WIDTH=5, TERMINAL=24, step 3
//                 u2 - WIDTH=4, TERMINAL=9,  step 7 (back-to-back wraps)
//               An arithmetic model checks every output of every instance on
//               each falling edge. Directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_counter;

`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int TERM [3] = '{31, 24, 9};
  localparam int STEP [3] = '{1, 3, 7};
  localparam int LVMOD[3] = '{32, 32, 16};   // load_val range each instance sees

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clear = 1'b0, load = 1'b0;
  logic [4:0] load_val = '0;

  logic [4:0] c0, c1;
  logic [3:0] c2;
  logic [2:0] ovf, sticky;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  up_counter #(.WIDTH(5), .INCREMENT_RATE(1), .TERMINAL(31)) u0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .count_val(c0), .overflow(ovf[0]),
    .overflow_sticky(sticky[0]));

  up_counter #(.WIDTH(5), .INCREMENT_RATE(3), .TERMINAL(24)) u1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
    .load_val(load_val), .count_val(c1), .overflow(ovf[1]),
    .overflow_sticky(sticky[1]));

  up_counter #(.WIDTH(4), .INCREMENT_RATE(7), .TERMINAL(9)) u2 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .load(load),
    .load_val(load_val[3:0]), .count_val(c2), .overflow(ovf[2]),
    .overflow_sticky(sticky[2]));

  // ---------------- behavioural model (plain integer arithmetic) ----------
  int mc[3], mo[3], ms[3], msat[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mc[i] <= 0; mo[i] <= 0; ms[i] <= 0; msat[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear) begin
          mc[i] <= 0; mo[i] <= 0; ms[i] <= 0; msat[i] <= 0;
        end else if (load) begin
          mc[i]   <= ((int'(load_val) % LVMOD[i]) > TERM[i]) ? TERM[i]
                                                           : (int'(load_val) % LVMOD[i]);
          mo[i]   <= 0;
          msat[i] <= 0;
        end else if (en) begin
          if (mc[i] + STEP[i] > TERM[i]) begin
            mc[i]   <= SAT ? TERM[i] : (mc[i] + STEP[i]) % (TERM[i] + 1);
            mo[i]   <= SAT ? int'(msat[i] == 0) : 1;
            ms[i]   <= 1;
            msat[i] <= 1;
          end else begin
            mc[i] <= mc[i] + STEP[i];
            mo[i] <= 0;
          end
        end else begin
          mo[i] <= 0;
        end
      end
    end
  end

  function automatic int dut_count(input int i);
    case (i)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      for (int i = 0; i < 3; i++) begin
        checks += 3;
        if (dut_count(i) != mc[i]) begin
          failures++;
          $display("FAIL model_count u%0d t=%0t got=%0d exp=%0d", i, $time, dut_count(i), mc[i]);
        end
        if (int'(ovf[i]) != mo[i]) begin
          failures++;
          $display("FAIL model_ovf u%0d t=%0t got=%0d exp=%0d", i, $time, ovf[i], mo[i]);
        end
        if (int'(sticky[i]) != ms[i]) begin
          failures++;
          $display("FAIL model_sticky u%0d t=%0t got=%0d exp=%0d", i, $time, sticky[i], ms[i]);
        end
      end
    end
  end

  // ---------------- directed stimulus with literal checks -----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected u2 sequence from 0 with step 7 mod 10
  int b2b_cnt[8] = '{7, 4, 1, 8, 5, 2, 9, 6};
  int b2b_ovf[8] = '{0, 1, 1, 0, 1, 1, 0, 1};

  initial begin
    #2;
    chk("reset_count", int'(c0), 0);
    chk("reset_ovf", int'(ovf[0]), 0);
    chk("reset_sticky", int'(sticky[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;

`ifndef UP_COUNTER_SATURATE_EN
    // Run a full lap and the first wrap.
    en = 1'b1;
    repeat (31) tick();
    chk("lap_count31", int'(c0), 31);
    chk("lap_no_ovf", int'(ovf[0]), 0);
    tick();
    chk("wrap_count", int'(c0), 0);
    chk("wrap_ovf", int'(ovf[0]), 1);
    chk("wrap_sticky", int'(sticky[0]), 1);
    en = 1'b0;
    tick();
    chk("ovf_one_cycle", int'(ovf[0]), 0);
    chk("sticky_holds", int'(sticky[0]), 1);

    // clear beats load and en on the same edge.
    load = 1'b1; load_val = 5'd10;
    tick();
    chk("load10", int'(c0), 10);
    clear = 1'b1; en = 1'b1;
    tick();
    chk("clear_prio_count", int'(c0), 0);
    chk("clear_prio_sticky", int'(sticky[0]), 0);
    clear = 1'b0; load = 1'b0;
    tick();
    chk("after_clear_count", int'(c0), 1);
    en = 1'b0;

    // Async reset in the middle of a count.
    load = 1'b1; load_val = 5'd17;
    tick();
    load = 1'b0;
    chk("load17", int'(c0), 17);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(c0), 0);
    chk("async_rst_ovf", int'(ovf[0]), 0);
    chk("async_rst_sticky", int'(sticky[1]), 0);
    #1 rst = 1'b0;
    en = 1'b1;
    tick();
    chk("resume_count", int'(c0), 1);
    en = 1'b0;

    // TERMINAL=24, step 3, starting from 23.
    load = 1'b1; load_val = 5'd23;
    tick();
    load = 1'b0;
    chk("u1_load23", int'(c1), 23);
    en = 1'b1;
    tick();
    chk("u1_wrap_count", int'(c1), 1);
    chk("u1_wrap_ovf", int'(ovf[1]), 1);
    chk("u1_wrap_sticky", int'(sticky[1]), 1);
    tick();
    chk("u1_next_count", int'(c1), 4);
    chk("u1_next_ovf", int'(ovf[1]), 0);
    en = 1'b0;

    // Load 30, then hold with en low. u1 clamps the load to its TERMINAL.
    load = 1'b1; load_val = 5'd30;
    tick();
    load = 1'b0;
    chk("load30", int'(c0), 30);
    chk("u1_load_clamp", int'(c1), 24);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_count", int'(c0), 30);
      chk("hold_ovf", int'(ovf[0]), 0);
    end

    // Back-to-back wraps on u2.
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_count", int'(c2), b2b_cnt[k]);
      chk("b2b_ovf", int'(ovf[2]), b2b_ovf[k]);
    end
    en = 1'b0;
`else
    // Saturate from 30: exactly one pulse, and the count pins at 31.
    begin
      int pulses;
      pulses = 0;
      load = 1'b1; load_val = 5'd30;
      tick();
      load = 1'b0;
      chk("sat_load30", int'(c0), 30);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk("sat_count", int'(c0), 31);
        pulses += int'(ovf[0]);
      end
      chk("sat_pulses", pulses, 1);
      chk("sat_sticky", int'(sticky[0]), 1);
      en = 1'b0;
      load = 1'b1; load_val = 5'd5;
      tick();
      load = 1'b0;
      chk("sat_leave_load", int'(c0), 5);
    end
`endif

    tick();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
